// File: rtl/dual_fetch_queue.sv
// dual_fetch_queue: decoupling queue between the dual-port instruction memory and the
// dual-issue decode stage. Accepts a sequential fetch pair (pc, pc+4) per cycle and presents
// the two oldest entries to decode, which retires 0/1/2 of them per cycle.
// Optional feature: define FETCHQ_BYPASS_EN to forward an enqueue into an empty queue
// straight to the outputs in the same cycle.
module dual_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid0,
    input  logic [XLEN-1:0] in_pc0,
    input  logic [XLEN-1:0] in_instr0,
    input  logic            in_valid1,
    input  logic [XLEN-1:0] in_instr1,
    output logic            in_ready,
    output logic            out_valid0,
    output logic [XLEN-1:0] out_pc0,
    output logic [XLEN-1:0] out_instr0,
    output logic            out_valid1,
    output logic [XLEN-1:0] out_pc1,
    output logic [XLEN-1:0] out_instr1,
    input  logic [1:0]      deq_cnt,
    output logic [CW-1:0]   count
);

    localparam int unsigned AW = CW - 1;
    // in_ready holds while at least two slots are free
    localparam logic [CW-1:0] ReadyMax = CW'(DEPTH - 2);

    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] instr_q [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;

    logic [AW-1:0] rd_idx0, rd_idx1, wr_idx0, wr_idx1;
    logic          enq_fire;
    logic [1:0]    enq_n;
    logic [1:0]    deq_clip;
    logic [CW-1:0] eff_store;
    logic [XLEN-1:0] slot1_pc;

    logic            we0, we1;
    logic [XLEN-1:0] wd0_pc, wd0_instr;
    logic [1:0]      wr_n;

    assign in_ready = (count_q <= ReadyMax);
    assign count    = count_q;
    assign slot1_pc = in_pc0 + XLEN'(4);
    assign rd_idx0  = rd_ptr_q[AW-1:0];
    assign rd_idx1  = rd_idx0 + AW'(1);
    assign wr_idx0  = wr_ptr_q[AW-1:0];
    assign wr_idx1  = wr_idx0 + AW'(1);

    // Enqueue/dequeue sizing; over-requests from decode are clipped to what is stored
    always_comb begin
        enq_fire  = in_valid0 && in_ready && !flush;
        enq_n     = enq_fire ? (in_valid1 ? 2'd2 : 2'd1) : 2'd0;
        deq_clip  = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
        eff_store = (CW'(deq_clip) > count_q) ? count_q : CW'(deq_clip);
    end

`ifdef FETCHQ_BYPASS_EN
    logic       byp_active;
    logic [1:0] eff_byp;

    assign byp_active = enq_fire && (count_q == '0);
    assign eff_byp    = (deq_clip > enq_n) ? enq_n : deq_clip;

    // Write selection: bypassed entries consumed by decode are never stored
    always_comb begin
        we0       = enq_fire;
        we1       = enq_fire && in_valid1;
        wd0_pc    = in_pc0;
        wd0_instr = in_instr0;
        wr_n      = enq_n;
        if (byp_active) begin
            wr_n = enq_n - eff_byp;
            if (eff_byp != 2'd0) begin
                we1 = 1'b0;
                // only slot1 can survive a partial consume
                we0       = (wr_n != 2'd0);
                wd0_pc    = slot1_pc;
                wd0_instr = in_instr1;
            end
        end
    end

    // Output mux: bypass when empty, storage otherwise, all-zero on flush
    always_comb begin
        out_valid0 = (count_q >= CW'(1));
        out_valid1 = (count_q >= CW'(2));
        out_pc0    = out_valid0 ? pc_q[rd_idx0]    : '0;
        out_instr0 = out_valid0 ? instr_q[rd_idx0] : '0;
        out_pc1    = out_valid1 ? pc_q[rd_idx1]    : '0;
        out_instr1 = out_valid1 ? instr_q[rd_idx1] : '0;
        if (flush) begin
            out_valid0 = 1'b0;
            out_valid1 = 1'b0;
            out_pc0    = '0;
            out_instr0 = '0;
            out_pc1    = '0;
            out_instr1 = '0;
        end else if (byp_active) begin
            out_valid0 = 1'b1;
            out_pc0    = in_pc0;
            out_instr0 = in_instr0;
            out_valid1 = in_valid1;
            out_pc1    = in_valid1 ? slot1_pc  : '0;
            out_instr1 = in_valid1 ? in_instr1 : '0;
        end
    end
`else
    // Write selection: slot0 at wr_ptr, slot1 right behind it
    always_comb begin
        we0       = enq_fire;
        we1       = enq_fire && in_valid1;
        wd0_pc    = in_pc0;
        wd0_instr = in_instr0;
        wr_n      = enq_n;
    end

    // Outputs come from storage only, zeroed when the matching entry is absent
    always_comb begin
        out_valid0 = (count_q >= CW'(1));
        out_valid1 = (count_q >= CW'(2));
        out_pc0    = out_valid0 ? pc_q[rd_idx0]    : '0;
        out_instr0 = out_valid0 ? instr_q[rd_idx0] : '0;
        out_pc1    = out_valid1 ? pc_q[rd_idx1]    : '0;
        out_instr1 = out_valid1 ? instr_q[rd_idx1] : '0;
    end
`endif

    // Next-state for occupancy and pointers; flush wins over enqueue and dequeue
    always_comb begin
        count_d  = count_q + CW'(wr_n) - eff_store;
        rd_ptr_d = rd_ptr_q + eff_store;
        wr_ptr_d = wr_ptr_q + CW'(wr_n);
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    // Occupancy and pointer registers; reset beats flush
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage; contents are never cleared, validity comes from count
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (we0) begin
                pc_q[wr_idx0]    <= wd0_pc;
                instr_q[wr_idx0] <= wd0_instr;
            end
            if (we1) begin
                pc_q[wr_idx1]    <= slot1_pc;
                instr_q[wr_idx1] <= in_instr1;
            end
        end
    end

    // Slot1 without slot0 is a fetch-side protocol error; it is dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(in_valid1 && !in_valid0))
            else $warning("dual_fetch_queue: in_valid1 without in_valid0 ignored");
        end
    end

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Directed bench for dual_fetch_queue (DEPTH=4, XLEN=32).
module tb_dual_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid0;
    logic [XLEN-1:0] in_pc0;
    logic [XLEN-1:0] in_instr0;
    logic            in_valid1;
    logic [XLEN-1:0] in_instr1;
    logic            in_ready;
    logic            out_valid0;
    logic [XLEN-1:0] out_pc0;
    logic [XLEN-1:0] out_instr0;
    logic            out_valid1;
    logic [XLEN-1:0] out_pc1;
    logic [XLEN-1:0] out_instr1;
    logic [1:0]      deq_cnt;
    logic [CW-1:0]   count;

    int nvec;
    int nerr;

    dual_fetch_queue #(
        .DEPTH(DEPTH),
        .XLEN (XLEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid0 (in_valid0),
        .in_pc0    (in_pc0),
        .in_instr0 (in_instr0),
        .in_valid1 (in_valid1),
        .in_instr1 (in_instr1),
        .in_ready  (in_ready),
        .out_valid0(out_valid0),
        .out_pc0   (out_pc0),
        .out_instr0(out_instr0),
        .out_valid1(out_valid1),
        .out_pc1   (out_pc1),
        .out_instr1(out_instr1),
        .deq_cnt   (deq_cnt),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word tagged from its pc so order errors show up in data too
    function automatic logic [31:0] iw(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic idle();
        flush     = 1'b0;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        in_pc0    = '0;
        in_instr0 = '0;
        in_instr1 = '0;
        deq_cnt   = 2'd0;
    endtask

    task automatic drive(input logic v0, input logic v1, input logic [31:0] pc,
                         input logic [1:0] deq, input logic fl);
        in_valid0 = v0;
        in_valid1 = v1;
        in_pc0    = pc;
        in_instr0 = iw(pc);
        in_instr1 = iw(pc + 32'd4);
        deq_cnt   = deq;
        flush     = fl;
    endtask

    // Advance one clock, then sample 1 time unit after the edge with inputs idle
    task automatic cycle();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", count); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b want 1", in_ready); end
        nvec++; if ({out_valid0, out_valid1} !== 2'b00) begin
            nerr++; $display("FAIL reset_valid got %b want 00", {out_valid0, out_valid1});
        end
        nvec++; if ({out_pc0, out_instr0, out_pc1, out_instr1} !== 128'd0) begin
            nerr++; $display("FAIL reset_data got %h want 0", {out_pc0, out_instr0, out_pc1, out_instr1});
        end
    endtask

    task automatic test_pair_enqueue();
        in_valid0 = 1'b1; in_valid1 = 1'b1; in_pc0 = 32'h0;
        in_instr0 = 32'h0050_0093; in_instr1 = 32'h00A0_0113; deq_cnt = 2'd0;
        cycle();
        nvec++; if (count !== 3'd2) begin nerr++; $display("FAIL pair_count got %0d want 2", count); end
        nvec++; if (out_pc0 !== 32'h0 || out_pc1 !== 32'h4) begin
            nerr++; $display("FAIL pair_pc got %h/%h want 0/4", out_pc0, out_pc1);
        end
        nvec++; if (out_instr0 !== 32'h0050_0093 || out_instr1 !== 32'h00A0_0113) begin
            nerr++; $display("FAIL pair_instr got %h/%h want 00500093/00a00113", out_instr0, out_instr1);
        end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL pair_ready got %b want 1", in_ready); end
    endtask

    task automatic test_full();
        drive(1'b1, 1'b1, 32'h8, 2'd0, 1'b0);
        cycle();
        nvec++; if (count !== 3'd4 || in_ready !== 1'b0) begin
            nerr++; $display("FAIL full_fill got count=%0d ready=%b want 4/0", count, in_ready);
        end
        drive(1'b1, 1'b0, 32'h40, 2'd0, 1'b0);
        cycle();
        nvec++; if (count !== 3'd4 || out_pc0 !== 32'h0) begin
            nerr++; $display("FAIL full_drop got count=%0d pc0=%h want 4/0", count, out_pc0);
        end
        drive(1'b0, 1'b0, 32'h0, 2'd1, 1'b0);
        cycle();
        nvec++; if (count !== 3'd3 || in_ready !== 1'b0) begin
            nerr++; $display("FAIL full_deq1 got count=%0d ready=%b want 3/0", count, in_ready);
        end
        nvec++; if (out_pc0 !== 32'h4 || out_pc1 !== 32'h8 || out_instr1 !== iw(32'h8)) begin
            nerr++; $display("FAIL full_order got %h/%h/%h want 4/8/%h", out_pc0, out_pc1, out_instr1, iw(32'h8));
        end
    endtask

    task automatic test_clip();
        // count 3 -> deq_cnt=3 behaves as 2
        drive(1'b0, 1'b0, 32'h0, 2'd3, 1'b0);
        cycle();
        nvec++; if (count !== 3'd1 || out_pc0 !== 32'hC || out_valid1 !== 1'b0 || out_pc1 !== 32'h0) begin
            nerr++; $display("FAIL clip_deq3 got count=%0d pc0=%h v1=%b pc1=%h want 1/c/0/0",
                             count, out_pc0, out_valid1, out_pc1);
        end
        drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b0);
        cycle();
        nvec++; if (count !== 3'd0 || out_valid0 !== 1'b0 || in_ready !== 1'b1) begin
            nerr++; $display("FAIL clip_over got count=%0d v0=%b ready=%b want 0/0/1", count, out_valid0, in_ready);
        end
        drive(1'b0, 1'b1, 32'h80, 2'd0, 1'b0);
        cycle();
        nvec++; if (count !== 3'd0 || out_valid0 !== 1'b0) begin
            nerr++; $display("FAIL slot1_alone got count=%0d v0=%b want 0/0", count, out_valid0);
        end
    endtask

    task automatic test_wrap();
        // Pointers sit at 4 (index 0); these steps push the write pointer past DEPTH
        drive(1'b1, 1'b1, 32'h200, 2'd0, 1'b0);
        cycle();
        drive(1'b1, 1'b1, 32'h208, 2'd1, 1'b0);
        cycle();
        nvec++; if (count !== 3'd3 || out_pc0 !== 32'h204 || out_pc1 !== 32'h208) begin
            nerr++; $display("FAIL wrap_a got count=%0d %h/%h want 3/204/208", count, out_pc0, out_pc1);
        end
        drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b0);
        cycle();
        nvec++; if (count !== 3'd1 || out_pc0 !== 32'h20C) begin
            nerr++; $display("FAIL wrap_b got count=%0d pc0=%h want 1/20c", count, out_pc0);
        end
        drive(1'b1, 1'b1, 32'h210, 2'd1, 1'b0);
        cycle();
        nvec++; if (count !== 3'd2 || out_pc0 !== 32'h210 || out_pc1 !== 32'h214
                    || out_instr1 !== iw(32'h214)) begin
            nerr++; $display("FAIL wrap_c got count=%0d %h/%h/%h want 2/210/214/%h",
                             count, out_pc0, out_pc1, out_instr1, iw(32'h214));
        end
        drive(1'b1, 1'b1, 32'h218, 2'd2, 1'b0);
        cycle();
        nvec++; if (count !== 3'd2 || out_pc0 !== 32'h218 || out_pc1 !== 32'h21C
                    || out_instr0 !== iw(32'h218)) begin
            nerr++; $display("FAIL wrap_d got count=%0d %h/%h/%h want 2/218/21c/%h",
                             count, out_pc0, out_pc1, out_instr0, iw(32'h218));
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 32'h280, 2'd2, 1'b1);
        cycle();
        nvec++; if (count !== 3'd0 || {out_valid0, out_valid1} !== 2'b00 || in_ready !== 1'b1) begin
            nerr++; $display("FAIL flush got count=%0d v=%b ready=%b want 0/00/1",
                             count, {out_valid0, out_valid1}, in_ready);
        end
        drive(1'b1, 1'b0, 32'h300, 2'd0, 1'b0);
        cycle();
        nvec++; if (count !== 3'd1 || out_pc0 !== 32'h300 || out_instr0 !== iw(32'h300)) begin
            nerr++; $display("FAIL flush_refill got count=%0d pc0=%h want 1/300", count, out_pc0);
        end
        // Reset beats a same-cycle flush and enqueue
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h380, 2'd0, 1'b1);
        cycle();
        rst = 1'b0;
        nvec++; if (count !== 3'd0 || out_valid0 !== 1'b0) begin
            nerr++; $display("FAIL reset_midop got count=%0d v0=%b want 0/0", count, out_valid0);
        end
    endtask

`ifdef FETCHQ_BYPASS_EN
    task automatic test_bypass();
        drive(1'b1, 1'b1, 32'h100, 2'd1, 1'b0);
        #1;
        nvec++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'h100 || out_pc1 !== 32'h104) begin
            nerr++; $display("FAIL bypass_same got v0=%b %h/%h want 1/100/104", out_valid0, out_pc0, out_pc1);
        end
        cycle();
        nvec++; if (count !== 3'd1 || out_pc0 !== 32'h104 || out_instr0 !== iw(32'h104)) begin
            nerr++; $display("FAIL bypass_next got count=%0d pc0=%h want 1/104", count, out_pc0);
        end
    endtask
`else
    task automatic test_latency();
        drive(1'b1, 1'b1, 32'h100, 2'd0, 1'b0);
        #1;
        nvec++; if (out_valid0 !== 1'b0 || out_pc0 !== 32'h0) begin
            nerr++; $display("FAIL latency_same got v0=%b pc0=%h want 0/0", out_valid0, out_pc0);
        end
        cycle();
        nvec++; if (count !== 3'd2 || out_pc0 !== 32'h100 || out_pc1 !== 32'h104) begin
            nerr++; $display("FAIL latency_next got count=%0d %h/%h want 2/100/104", count, out_pc0, out_pc1);
        end
    endtask
`endif

    initial begin
        nvec = 0;
        nerr = 0;
        rst  = 1'b1;
        idle();
        test_reset();
        test_pair_enqueue();
        test_full();
        test_clip();
        test_wrap();
        test_flush();
`ifdef FETCHQ_BYPASS_EN
        test_bypass();
`else
        test_latency();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
